// File: rtl/x448_pkg.sv
// Shared definitions for the X448 scalar path: frame geometry, field prime,
// loader state encoding and the RFC 7748 scalar clamp.
package x448_pkg;

  localparam int NBYTES = 56;
  localparam int W      = 8 * NBYTES;
  localparam int CW     = $clog2(NBYTES);

  // p = 2^448 - 2^224 - 1
  localparam logic [W-1:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } ld_state_e;

  // Clear the two cofactor bits and force the top bit.
  function automatic logic [W-1:0] x448_clamp(input logic [W-1:0] k);
    logic [W-1:0] r;
    r        = k;
    r[1:0]   = 2'b00;
    r[W-1]   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/x448_scalar_loader.sv
// X448 scalar loader: collects a 56-byte little-endian scalar from a byte
// stream, optionally clamps it and offers it to the scalarmult engine over a
// valid/ready request handshake. Malformed frames are dropped and flagged.
// Build option: define X448_SCALAR_CLAMP_EN to clamp K as the frame completes;
// otherwise K carries the raw bytes.
module x448_scalar_loader
  import x448_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] K,
  output logic         req_valid,
  input  logic         req_ready,
  output logic         frame_err,
  output logic         busy
);

  ld_state_e       r_state;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_k;
  logic            r_req_valid;
  logic            r_frame_err;
  logic            r_in_ready;
  logic            r_busy;

  logic            w_byte_acc;
  logic            w_at_end;
  logic [W-1:0]    w_k_ins;
  logic [W-1:0]    w_k_fin;

  assign w_byte_acc = in_valid & r_in_ready;
  assign w_at_end   = (r_count == CW'(NBYTES - 1));

  // Current K with the incoming byte dropped into its slot.
  always_comb begin
    w_k_ins                  = r_k;
    w_k_ins[8*r_count +: 8]  = in_data;
  end

`ifdef X448_SCALAR_CLAMP_EN
  assign w_k_fin = x448_clamp(w_k_ins);
`else
  assign w_k_fin = w_k_ins;
`endif

  // Loader FSM; in_ready and busy are registered from the next state so
  // every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_k         <= '0;
      r_req_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      unique case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_byte_acc) begin
            if (in_last && !w_at_end) begin
              // Short frame: drop the partial scalar.
              r_k         <= w_k_ins;
              r_frame_err <= 1'b1;
              r_count     <= '0;
              r_busy      <= 1'b0;
            end else if (in_last) begin
              // Complete frame: latch final K and hand it to the engine.
              r_k         <= w_k_fin;
              r_state     <= HOLD;
              r_req_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b1;
            end else if (w_at_end) begin
              // Long frame: flag once, swallow the rest up to in_last.
              r_k         <= w_k_ins;
              r_frame_err <= 1'b1;
              r_state     <= DISCARD;
              r_count     <= '0;
              r_busy      <= 1'b1;
            end else begin
              r_k         <= w_k_ins;
              r_count     <= r_count + CW'(1);
              r_busy      <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_count     <= '0;
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DISCARD: begin
          r_in_ready <= 1'b1;
          if (w_byte_acc && in_last) begin
            r_state <= FILL;
            r_count <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= FILL;
          r_count     <= '0;
          r_req_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign K         = r_k;
  assign req_valid = r_req_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_x448_scalar_loader.sv
// Self-checking bench for x448_scalar_loader: randomized byte gaps and data,
// expected K computed arithmetically from the frame bytes.
module tb_x448_scalar_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [447:0] K;
  logic         req_valid;
  logic         req_ready;
  logic         frame_err;
  logic         busy;

  logic rand_rr = 1'b0;
  logic rr_drv  = 1'b0;
  logic rr_rnd  = 1'b0;
  assign req_ready = rand_rr ? rr_rnd : rr_drv;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]   frame_data [0:63];
  int           acc_cyc    [0:63];
  logic [447:0] req_q[$];
  int           req_cyc_q[$];
  int           err_cnt = 0;
  int           err_cyc = -1;
  int           rv_cnt  = 0;

  x448_scalar_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .K(K), .req_valid(req_valid),
    .req_ready(req_ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rr_rnd = 1'($urandom_range(1));
  end

  // Observe handshakes mid-cycle, where everything is stable for the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        req_q.push_back(K);
        req_cyc_q.push_back(cyc);
      end
      if (frame_err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      if (req_valid) rv_cnt = rv_cnt + 1;
    end
  end

  // Expected scalar: little-endian sum of the first 56 bytes, then clamp.
  function automatic logic [447:0] ref_k();
    logic [447:0] k;
    k = '0;
    for (int i = 0; i < 56; i++) k = k + ({440'd0, frame_data[i]} << (8 * i));
`ifdef X448_SCALAR_CLAMP_EN
    k = (k & ~448'd3) | (448'd1 << 447);
`endif
    return k;
  endfunction

  task automatic clear_mon();
    req_q.delete();
    req_cyc_q.delete();
    err_cnt = 0;
    err_cyc = -1;
    rv_cnt  = 0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) frame_data[i] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n bytes with random valid gaps; in_last on index last_at.
  task automatic send_frame(input int n, input int last_at);
    int i;
    int waited;
    logic v;
    i = 0;
    waited = 0;
    while (i < n) begin
      @(posedge clk); #1;
      v        = ($urandom_range(3) != 0);
      in_valid = v;
      in_data  = frame_data[i];
      in_last  = (i == last_at);
      if (v && in_ready) begin
        acc_cyc[i] = cyc;
        i = i + 1;
        waited = 0;
      end else begin
        waited = waited + 1;
        if (waited > 300) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL send_frame timeout: byte %0d not accepted, in_ready=%0b required 1", i, in_ready);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks = checks + 1;
    if ({in_ready, req_valid, frame_err, busy} !== 4'b0000 || K !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_state: rdy=%0b rv=%0b err=%0b busy=%0b K=%h required all 0",
               in_ready, req_valid, frame_err, busy, K);
    end
    rst = 1'b0;
    idle(1);
    checks = checks + 1;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_release: in_ready=%0b busy=%0b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_ramp();
    logic [447:0] exp_k;
    logic [7:0]   exp_top;
    clear_mon();
    rand_rr = 1'b0;
    rr_drv  = 1'b1;
    for (int i = 0; i < 56; i++) frame_data[i] = 8'(i);
    exp_k = ref_k();
`ifdef X448_SCALAR_CLAMP_EN
    exp_top = 8'hB7;
`else
    exp_top = 8'h37;
`endif
    send_frame(56, 55);
    idle(4);
    checks = checks + 1;
    if (req_q.size() != 1) begin
      errors = errors + 1;
      $display("FAIL ramp_req_count: got %0d required 1", req_q.size());
    end else begin
      checks = checks + 4;
      if (req_q[0] !== exp_k) begin
        errors = errors + 1;
        $display("FAIL ramp_K: got %h required %h", req_q[0], exp_k);
      end
      if (req_q[0][447:440] !== exp_top || req_q[0][7:0] !== 8'h00) begin
        errors = errors + 1;
        $display("FAIL ramp_K_ends: top=%h low=%h required %h/00", req_q[0][447:440], req_q[0][7:0], exp_top);
      end
      if (req_q[0][15:8] !== 8'h01) begin
        errors = errors + 1;
        $display("FAIL ramp_K_byte1: got %h required 01", req_q[0][15:8]);
      end
      if (req_cyc_q[0] != acc_cyc[55] + 1) begin
        errors = errors + 1;
        $display("FAIL ramp_latency: req at %0d required %0d", req_cyc_q[0], acc_cyc[55] + 1);
      end
    end
    checks = checks + 1;
    if (rv_cnt != 1 || err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL ramp_pulse: req_valid cycles=%0d frame_err=%0d required 1/0", rv_cnt, err_cnt);
    end
  endtask

  task automatic test_all_ff();
    logic [447:0] exp_k;
    clear_mon();
    for (int i = 0; i < 56; i++) frame_data[i] = 8'hFF;
    exp_k = ref_k();
    send_frame(56, 55);
    idle(4);
    checks = checks + 1;
    if (req_q.size() != 1 || req_q[0] !== exp_k) begin
      errors = errors + 1;
      $display("FAIL all_ff_K: count=%0d K=%h required 1/%h", req_q.size(),
               (req_q.size() > 0) ? req_q[0] : 448'd0, exp_k);
    end
  endtask

  task automatic test_short_frame();
    logic [447:0] exp_k;
    clear_mon();
    fill_random(11);
    send_frame(11, 10);
    idle(4);
    checks = checks + 1;
    if (err_cnt != 1 || req_q.size() != 0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL short_frame: frame_err=%0d req=%0d busy=%0b required 1/0/0", err_cnt, req_q.size(), busy);
    end
    clear_mon();
    fill_random(56);
    exp_k = ref_k();
    send_frame(56, 55);
    idle(4);
    checks = checks + 1;
    if (req_q.size() != 1 || req_q[0] !== exp_k || err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL short_recover: req=%0d err=%0d K=%h required 1/0/%h", req_q.size(), err_cnt,
               (req_q.size() > 0) ? req_q[0] : 448'd0, exp_k);
    end
  endtask

  task automatic test_long_frame();
    logic [447:0] exp_k;
    clear_mon();
    fill_random(60);
    send_frame(60, 59);
    idle(4);
    checks = checks + 1;
    if (err_cnt != 1 || req_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL long_frame: frame_err=%0d req=%0d required 1/0", err_cnt, req_q.size());
    end
    checks = checks + 1;
    if (err_cyc != acc_cyc[55] + 1) begin
      errors = errors + 1;
      $display("FAIL long_err_timing: err at %0d required %0d", err_cyc, acc_cyc[55] + 1);
    end
    clear_mon();
    fill_random(56);
    exp_k = ref_k();
    send_frame(56, 55);
    idle(4);
    checks = checks + 1;
    if (req_q.size() != 1 || req_q[0] !== exp_k || err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL long_recover: req=%0d err=%0d K=%h required 1/0/%h", req_q.size(), err_cnt,
               (req_q.size() > 0) ? req_q[0] : 448'd0, exp_k);
    end
  endtask

  task automatic test_backpressure();
    logic [447:0] exp_k;
    int bad;
    clear_mon();
    rand_rr = 1'b0;
    rr_drv  = 1'b0;
    fill_random(56);
    exp_k = ref_k();
    send_frame(56, 55);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_valid !== 1'b1 || K !== exp_k || in_ready !== 1'b0 || busy !== 1'b1) bad = bad + 1;
    end
    checks = checks + 1;
    if (bad != 0) begin
      errors = errors + 1;
      $display("FAIL backpressure_hold: %0d bad cycles required 0 (rv=%0b rdy=%0b)", bad, req_valid, in_ready);
    end
    @(posedge clk); #1;
    rr_drv = 1'b1;
    @(posedge clk); #1;
    rr_drv = 1'b0;
    checks = checks + 1;
    if (req_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL backpressure_release: rv=%0b rdy=%0b required 0/1", req_valid, in_ready);
    end
    idle(3);
    checks = checks + 1;
    if (req_q.size() != 1 || req_q[0] !== exp_k) begin
      errors = errors + 1;
      $display("FAIL backpressure_xfer: count=%0d required 1", req_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [447:0] exp_k;
    clear_mon();
    rr_drv = 1'b1;
    fill_random(20);
    send_frame(20, -1);
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL mid_busy: busy=%0b required 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks = checks + 1;
    if ({in_ready, req_valid, frame_err, busy} !== 4'b0000 || K !== '0) begin
      errors = errors + 1;
      $display("FAIL mid_reset_state: rdy=%0b rv=%0b err=%0b busy=%0b K=%h required all 0",
               in_ready, req_valid, frame_err, busy, K);
    end
    for (int i = 0; i < 56; i++) frame_data[i] = 8'hA5;
    exp_k = ref_k();
    send_frame(56, 55);
    idle(4);
    checks = checks + 1;
    if (req_q.size() != 1 || req_q[0] !== exp_k) begin
      errors = errors + 1;
      $display("FAIL mid_reset_frame: count=%0d K=%h required 1/%h", req_q.size(),
               (req_q.size() > 0) ? req_q[0] : 448'd0, exp_k);
    end else begin
      checks = checks + 1;
`ifdef X448_SCALAR_CLAMP_EN
      if (req_q[0][7:0] !== 8'hA4 || req_q[0][447:440] !== 8'hA5) begin
`else
      if (req_q[0][7:0] !== 8'hA5 || req_q[0][447:440] !== 8'hA5) begin
`endif
        errors = errors + 1;
        $display("FAIL mid_reset_ends: low=%h top=%h", req_q[0][7:0], req_q[0][447:440]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [447:0] exp_q[$];
    int budget;
    clear_mon();
    rand_rr = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fill_random(56);
      exp_q.push_back(ref_k());
      send_frame(56, 55);
    end
    budget = 0;
    while (req_q.size() < 6 && budget < 100) begin
      @(posedge clk);
      budget = budget + 1;
    end
    #1;
    rand_rr = 1'b0;
    checks = checks + 1;
    if (req_q.size() != 6 || err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL b2b_count: req=%0d err=%0d required 6/0", req_q.size(), err_cnt);
    end else begin
      for (int f = 0; f < 6; f++) begin
        checks = checks + 1;
        if (req_q[f] !== exp_q[f]) begin
          errors = errors + 1;
          $display("FAIL b2b_K[%0d]: got %h required %h", f, req_q[f], exp_q[f]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_ff();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
